mem_fill_responder: RTL and testbench
=====================================

MEM_FILL_RESPONDER -- requirements
Module: mem_fill_responder

Interface
- REQ-001: Parameter LATENCY, default 4, cycles from read issue to data_valid; legal range 1..8.
- REQ-002: Parameter DEPTH_LOG2, default 8, log2 of the number of 16-bit words in the backing store; legal range 4..15.
- REQ-003: Port clk, input, 1, sole clock; all state updates on its rising edge.
- REQ-004: Port rst, input, 1, reset, synchronous, active-high.
- REQ-005: Port enable, input, 1, request valid this cycle.
- REQ-006: Port wr, input, 1, request type when enable=1 (1 = write, 0 = read).
- REQ-007: Port addr, input, 16, byte address; word index = addr[DEPTH_LOG2:1]; addr[0] ignored.
- REQ-008: Port data_in, input, 16, write data.
- REQ-009: Port data_out, output, 16, read data; meaningful only when data_valid=1.
- REQ-010: Port data_valid, output, 1, one-cycle pulse per returned read word.
- REQ-011: Port rd_pending, output, 4, count of reads issued and not yet returned.

Function
- REQ-012: Block SHALL accept one request per cycle with no backpressure; it is fully pipelined.
- REQ-013: Read (enable=1, wr=0) in cycle N SHALL sample the store at issue; data_valid=1 with that word on data_out in cycle N+LATENCY exactly.
- REQ-014: Back-to-back reads SHALL return in issue order, one per cycle, with no bubbles; up to LATENCY reads may be outstanding.
- REQ-015: Write (enable=1, wr=1) in cycle N SHALL update the store at the end of cycle N; writes produce no data_valid.
- REQ-016: Read issued in cycle N+1 or later after a write to the same word SHALL return the written data.
- REQ-017: Reads issued before a write to the same word SHALL return the old data, even if they return after the write.
- REQ-018: data_out SHALL be 16'h0000 whenever data_valid=0.
- REQ-019: rd_pending SHALL increment on read issue, decrement on data_valid, stay unchanged when both occur in one cycle, and never exceed LATENCY.
- REQ-020: enable=0 SHALL leave the store and pipeline issue slot idle; wr and data_in are ignored.
- REQ-021: Without REQ-026, address bits above DEPTH_LOG2 SHALL be ignored, so addresses alias modulo 2^(DEPTH_LOG2+1) bytes.
- REQ-022: An 8-word line fill issued at consecutive addresses base+0, +2, ... +14 SHALL return 8 data_valid pulses in cycles issue+LATENCY through issue+LATENCY+7.

Reset
- REQ-023: While rst=1, the block SHALL clear all in-flight pipeline entries and hold data_valid=0, data_out=0, and rd_pending=0.
- REQ-024: Reset asserted mid-burst SHALL drop all outstanding reads; no data_valid occurs for them after rst deasserts.
- REQ-025: Store contents SHALL be unaffected by rst, and requests presented while rst=1 SHALL be ignored.

Configuration
- REQ-026: Macro MEM_RESP_OOR_CHK_EN defined SHALL add output port addr_err (1 bit) and range-check addr[15:DEPTH_LOG2+1]; any nonzero bit marks the request out of range.
- REQ-027: With the macro, an out-of-range read SHALL still return data_valid at normal latency, with data_out=0 and addr_err=1 in that same cycle.
- REQ-028: With the macro, an out-of-range write SHALL not modify the store and SHALL pulse addr_err in the following cycle.
- REQ-029: With the macro, addr_err SHALL be 0 at all other times, including during reset.
- REQ-030: Without the macro, the addr_err port SHALL not exist and aliasing per REQ-021 applies.

Verification
- REQ-031: Write 16'hBEEF at 16'h0010, then read 16'h0010 the next cycle -> data_valid with 16'hBEEF exactly 4 cycles after the read.
- REQ-032: 8 back-to-back reads at 16'h0020..16'h002E after preloading 16'h1000+i -> 8 consecutive valid pulses with 16'h1000..16'h1007; rd_pending peaks at 4.
- REQ-033: Read 16'h0040 holding 16'h1111, write 16'h2222 there the next cycle -> the read returns 16'h1111; a later read returns 16'h2222.
- REQ-034: Issue 3 reads, assert rst for 1 cycle 2 cycles after the first -> no data_valid afterwards, rd_pending=0, store unchanged.
- REQ-035: LATENCY=1 with alternating read/write each cycle -> each read valid the next cycle; no valid for writes.
- REQ-036: MEM_RESP_OOR_CHK_EN, DEPTH_LOG2=8: read 16'h0200 -> data_out=0 with addr_err=1 at cycle+4; write 16'h0300 -> addr_err next cycle and word 0 unchanged.

Source files
------------

// File: rtl/mem_fill_if.sv
// mem_fill_if -- request/response bundle for mem_fill_responder.
//
// Signals:
//   enable     : request valid this cycle (master -> slave)
//   wr         : 1 = write, 0 = read, meaningful when enable=1
//   addr       : 16-bit byte address, bit 0 ignored
//   data_in    : write data
//   data_out   : read data, 16'h0000 whenever data_valid=0
//   data_valid : one-cycle pulse per returned read word
//   rd_pending : reads issued and not yet returned
//   addr_err   : out-of-range flag, present only when MEM_RESP_OOR_CHK_EN is defined
//
// Optional feature macro: MEM_RESP_OOR_CHK_EN
interface mem_fill_if;
   logic        enable;
   logic        wr;
   logic [15:0] addr;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        data_valid;
   logic [3:0]  rd_pending;
`ifdef MEM_RESP_OOR_CHK_EN
   logic        addr_err;

   modport master (output enable, wr, addr, data_in,
                   input  data_out, data_valid, rd_pending, addr_err);
   modport slave  (input  enable, wr, addr, data_in,
                   output data_out, data_valid, rd_pending, addr_err);
`else
   modport master (output enable, wr, addr, data_in,
                   input  data_out, data_valid, rd_pending);
   modport slave  (input  enable, wr, addr, data_in,
                   output data_out, data_valid, rd_pending);
`endif
endinterface

// File: rtl/mem_fill_responder.sv
// mem_fill_responder -- fully pipelined 16-bit word store answering reads
// after a fixed LATENCY, with no backpressure.
//
// Parameters:
//   LATENCY    : cycles from read issue to data_valid (1..8)
//   DEPTH_LOG2 : log2 of the number of 16-bit words (4..15)
//
// Ports:
//   clk : sole clock, rising edge
//   rst : synchronous active-high reset; clears the read pipeline and
//         rd_pending, leaves the store contents alone
//   bus : mem_fill_if.slave (enable, wr, addr, data_in in;
//         data_out, data_valid, rd_pending [, addr_err] out)
//
// Optional feature macro: MEM_RESP_OOR_CHK_EN
//   Defined   : addr[15:DEPTH_LOG2+1] must be zero. Out-of-range reads return
//               data_out=0 with addr_err=1 at normal latency; out-of-range
//               writes leave the store untouched and pulse addr_err next cycle.
//   Undefined : upper address bits are ignored (addresses alias).
module mem_fill_responder #(
   parameter int LATENCY    = 4,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic      clk,
   input  logic      rst,
   mem_fill_if.slave bus
);

   localparam int WORDS = 1 << DEPTH_LOG2;

   logic [15:0]           mem_r [WORDS];
   logic [DEPTH_LOG2-1:0] word_idx_s;
   logic                  oor_s;
   logic                  rd_issue_s;
   logic                  wr_issue_s;
   logic [15:0]           rd_word_s;
   logic [15:0]           pipe_data_r [LATENCY];
   logic [LATENCY-1:0]    pipe_vld_r;
   logic [3:0]            rd_pending_r;

   // Shift-then-truncate keeps addr[0] and the aliased upper bits out of the index.
   assign word_idx_s = DEPTH_LOG2'(bus.addr >> 1);

`ifdef MEM_RESP_OOR_CHK_EN
   assign oor_s = (bus.addr >> (DEPTH_LOG2 + 1)) != 16'h0000;
`else
   assign oor_s = 1'b0;
`endif

   // Decode the request; the store is sampled here so a read sees the value
   // before any later write, and requests during reset are dropped.
   always_comb begin
      rd_issue_s = 1'b0;
      wr_issue_s = 1'b0;
      rd_word_s  = 16'h0000;
      if (!rst && bus.enable) begin
         if (bus.wr) begin
            wr_issue_s = !oor_s;
         end else begin
            rd_issue_s = 1'b1;
            if (oor_s) begin
               rd_word_s = 16'h0000;
            end else begin
               rd_word_s = mem_r[word_idx_s];
            end
         end
      end else begin
         rd_issue_s = 1'b0;
      end
   end

   // Backing store write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (wr_issue_s) begin
         mem_r[word_idx_s] <= bus.data_in;
      end
   end

   // Read return pipeline; stage 0 captures at issue, last stage drives the outputs.
   // Data rides as zero in empty slots so data_out is 0 whenever data_valid is 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_vld_r <= {LATENCY{1'b0}};
         for (int i = 0; i < LATENCY; i++) begin
            pipe_data_r[i] <= 16'h0000;
         end
      end else begin
         pipe_vld_r[0]  <= rd_issue_s;
         pipe_data_r[0] <= rd_word_s;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_vld_r[i]  <= pipe_vld_r[i-1];
            pipe_data_r[i] <= pipe_data_r[i-1];
         end
      end
   end

   // Outstanding-read counter; equals the number of occupied pipeline slots.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pending_r <= 4'd0;
      end else begin
         case ({rd_issue_s, pipe_vld_r[LATENCY-1]})
            2'b10:   rd_pending_r <= rd_pending_r + 4'd1;
            2'b01:   rd_pending_r <= rd_pending_r - 4'd1;
            default: rd_pending_r <= rd_pending_r;
         endcase
      end
   end

   assign bus.data_out   = pipe_data_r[LATENCY-1];
   assign bus.data_valid = pipe_vld_r[LATENCY-1];
   assign bus.rd_pending = rd_pending_r;

`ifdef MEM_RESP_OOR_CHK_EN
   logic wr_oor_s;
   logic rd_err_feed_s;
   logic addr_err_r;

   assign wr_oor_s = !rst && bus.enable && bus.wr && oor_s;

   // The read error travels one stage behind the data pipeline so that
   // addr_err can be a register loaded in step with the returning word.
   if (LATENCY == 1) begin : g_err_l1
      assign rd_err_feed_s = rd_issue_s && oor_s;
   end else begin : g_err_ln
      logic [LATENCY-2:0] err_pipe_r;

      // Out-of-range flag for reads in flight.
      always_ff @(posedge clk) begin
         if (rst) begin
            err_pipe_r <= {(LATENCY-1){1'b0}};
         end else begin
            err_pipe_r[0] <= rd_issue_s && oor_s;
            for (int i = 1; i < LATENCY - 1; i++) begin
               err_pipe_r[i] <= err_pipe_r[i-1];
            end
         end
      end

      assign rd_err_feed_s = err_pipe_r[LATENCY-2];
   end

   // Registered error flag: read errors at return time, write errors one cycle after issue.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_err_r <= 1'b0;
      end else begin
         addr_err_r <= rd_err_feed_s || wr_oor_s;
      end
   end

   assign bus.addr_err = addr_err_r;
`endif

endmodule

// File: tb/tb_mem_fill_responder.sv
// Self-checking bench for mem_fill_responder: a LATENCY=4 instance driven
// from a table of per-cycle vectors plus hand-written multi-cycle sequences,
// and a LATENCY=1 instance exercised with alternating write/read.
module tb_mem_fill_responder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
`ifdef MEM_RESP_OOR_CHK_EN
   logic exp_err = 1'b0;
`endif

   always #5 clk = ~clk;

   mem_fill_if bus4 ();
   mem_fill_if bus1 ();

   mem_fill_responder #(.LATENCY(4), .DEPTH_LOG2(8)) u4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4.slave)
   );

   mem_fill_responder #(.LATENCY(1), .DEPTH_LOG2(8)) u1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1.slave)
   );

   typedef struct {
      logic        rs;
      logic        en;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] din;
      logic        v;
      logic [15:0] d;
      logic [3:0]  p;
   } row_t;

   row_t tbl[$];

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int idx,
                      input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   function automatic void add(input logic en, input logic wr,
                               input logic [15:0] a, input logic [15:0] din,
                               input logic v, input logic [15:0] d,
                               input logic [3:0] p);
      row_t r;
      r.rs = 1'b0; r.en = en; r.wr = wr; r.addr = a; r.din = din;
      r.v = v; r.d = d; r.p = p;
      tbl.push_back(r);
   endfunction

   // One cycle on the LATENCY=4 instance: check this cycle's outputs, then drive this cycle's inputs.
   task automatic run4(input string name, input int idx, input logic rs,
                       input logic en, input logic wr,
                       input logic [15:0] a, input logic [15:0] din,
                       input logic v, input logic [15:0] d, input logic [3:0] p);
      cyc();
      chk({name, ".valid"},   idx, {15'h0000, bus4.data_valid}, {15'h0000, v});
      chk({name, ".data"},    idx, bus4.data_out, d);
      chk({name, ".pending"}, idx, {12'h000, bus4.rd_pending}, {12'h000, p});
`ifdef MEM_RESP_OOR_CHK_EN
      chk({name, ".err"},     idx, {15'h0000, bus4.addr_err}, {15'h0000, exp_err});
`endif
      rst          = rs;
      bus4.enable  = en;
      bus4.wr      = wr;
      bus4.addr    = a;
      bus4.data_in = din;
   endtask

   // Same for the LATENCY=1 instance.
   task automatic run1(input string name, input int idx,
                       input logic en, input logic wr,
                       input logic [15:0] a, input logic [15:0] din,
                       input logic v, input logic [15:0] d, input logic [3:0] p);
      cyc();
      chk({name, ".valid"},   idx, {15'h0000, bus1.data_valid}, {15'h0000, v});
      chk({name, ".data"},    idx, bus1.data_out, d);
      chk({name, ".pending"}, idx, {12'h000, bus1.rd_pending}, {12'h000, p});
`ifdef MEM_RESP_OOR_CHK_EN
      chk({name, ".err"},     idx, {15'h0000, bus1.addr_err}, 16'h0000);
`endif
      bus1.enable  = en;
      bus1.wr      = wr;
      bus1.addr    = a;
      bus1.data_in = din;
   endtask

   initial begin
      logic [15:0] dk;
      logic [15:0] dprev;

      bus4.enable = 1'b0; bus4.wr = 1'b0; bus4.addr = 16'h0000; bus4.data_in = 16'h0000;
      bus1.enable = 1'b0; bus1.wr = 1'b0; bus1.addr = 16'h0000; bus1.data_in = 16'h0000;

      // Reset state of both instances.
      repeat (3) cyc();
      chk("reset4.valid",   0, {15'h0000, bus4.data_valid}, 16'h0000);
      chk("reset4.data",    0, bus4.data_out, 16'h0000);
      chk("reset4.pending", 0, {12'h000, bus4.rd_pending}, 16'h0000);
      chk("reset1.valid",   0, {15'h0000, bus1.data_valid}, 16'h0000);
      chk("reset1.data",    0, bus1.data_out, 16'h0000);
      chk("reset1.pending", 0, {12'h000, bus1.rd_pending}, 16'h0000);
`ifdef MEM_RESP_OOR_CHK_EN
      chk("reset4.err",     0, {15'h0000, bus4.addr_err}, 16'h0000);
`endif
      rst = 1'b0;

      // Rows 0-6: write BEEF @0x0010, read it next cycle, valid 4 cycles later.
      add(1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, 4'd0);
      add(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 4'd0);
      add(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd1);
      add(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd1);
      add(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd1);
      add(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF, 4'd1);
      add(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd0);
      // Rows 7-14: preload 0x1000+i at 0x0020+2i.
      for (int i = 0; i < 8; i++)
         add(1'b1, 1'b1, 16'h0020 + 16'(2*i), 16'h1000 + 16'(i), 1'b0, 16'h0000, 4'd0);
      // Rows 15-22: line fill, back-to-back reads.
      for (int i = 0; i < 8; i++)
         add(1'b1, 1'b0, 16'h0020 + 16'(2*i), 16'h0000,
             (i >= 4) ? 1'b1 : 1'b0,
             (i >= 4) ? 16'h1000 + 16'(i-4) : 16'h0000,
             (i >= 4) ? 4'd4 : 4'(i));
      // Rows 23-27: drain.
      for (int j = 0; j < 5; j++)
         add(1'b0, 1'b0, 16'h0000, 16'h0000,
             (j < 4) ? 1'b1 : 1'b0,
             (j < 4) ? 16'h1004 + 16'(j) : 16'h0000,
             4'(4-j));
      // Rows 28-36: read-before-write returns old data, later read the new.
      add(1'b1, 1'b1, 16'h0040, 16'h1111, 1'b0, 16'h0000, 4'd0);
      add(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0000, 4'd0);
      add(1'b1, 1'b1, 16'h0040, 16'h2222, 1'b0, 16'h0000, 4'd1);
      add(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0000, 4'd1);
      add(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd2);
      add(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1111, 4'd2);
      add(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd1);
      add(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h2222, 4'd1);
      add(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd0);
      // Rows 37-41: addr[0] ignored; row 38 is a disabled write that must be ignored.
      add(1'b1, 1'b0, 16'h0011, 16'h0000, 1'b0, 16'h0000, 4'd0);
      add(1'b0, 1'b1, 16'h0010, 16'hDEAD, 1'b0, 16'h0000, 4'd1);
      add(1'b0, 1'b1, 16'h0010, 16'hDEAD, 1'b0, 16'h0000, 4'd1);
      add(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd1);
      add(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF, 4'd1);
      // Rows 42-47: store still holds BEEF.
      add(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 4'd0);
      add(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd1);
      add(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd1);
      add(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd1);
      add(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF, 4'd1);
      add(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd0);

      for (int i = 0; i < tbl.size(); i++)
         run4("tbl", i, tbl[i].rs, tbl[i].en, tbl[i].wr, tbl[i].addr, tbl[i].din,
              tbl[i].v, tbl[i].d, tbl[i].p);

      // Reset mid-burst drops outstanding reads; a write during reset is ignored.
      run4("rstb", 0, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000, 4'd0);
      run4("rstb", 1, 1'b0, 1'b1, 1'b0, 16'h0022, 16'h0000, 1'b0, 16'h0000, 4'd1);
      run4("rstb", 2, 1'b1, 1'b1, 1'b0, 16'h0024, 16'h0000, 1'b0, 16'h0000, 4'd2);
      for (int k = 3; k < 10; k++)
         run4("rstb", k, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd0);
      run4("rstb", 10, 1'b1, 1'b1, 1'b1, 16'h0024, 16'hAAAA, 1'b0, 16'h0000, 4'd0);
      run4("rstb", 11, 1'b0, 1'b1, 1'b0, 16'h0024, 16'h0000, 1'b0, 16'h0000, 4'd0);
      run4("rstb", 12, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000, 4'd1);
      run4("rstb", 13, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd2);
      run4("rstb", 14, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd2);
      run4("rstb", 15, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1002, 4'd2);
      run4("rstb", 16, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1000, 4'd1);
      run4("rstb", 17, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd0);

`ifdef MEM_RESP_OOR_CHK_EN
      // Out-of-range read returns zero with addr_err; out-of-range write is dropped.
      run4("oor", 0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0A0A, 1'b0, 16'h0000, 4'd0);
      run4("oor", 1, 1'b0, 1'b1, 1'b1, 16'h0100, 16'h0B0B, 1'b0, 16'h0000, 4'd0);
      run4("oor", 2, 1'b0, 1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0, 16'h0000, 4'd0);
      run4("oor", 3, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd1);
      run4("oor", 4, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd1);
      run4("oor", 5, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd1);
      exp_err = 1'b1;
      run4("oor", 6, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 4'd1);
      exp_err = 1'b0;
      run4("oor", 7, 1'b0, 1'b1, 1'b1, 16'h0300, 16'h5555, 1'b0, 16'h0000, 4'd0);
      exp_err = 1'b1;
      run4("oor", 8, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd0);
      exp_err = 1'b0;
      run4("oor", 9, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd0);
      run4("oor", 10, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 16'h0000, 4'd1);
      run4("oor", 11, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd2);
      run4("oor", 12, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd2);
      run4("oor", 13, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0A0A, 4'd2);
      run4("oor", 14, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0B0B, 4'd1);
      run4("oor", 15, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd0);
`else
      // Upper address bits alias modulo 512 bytes.
      run4("alias", 0, 1'b0, 1'b1, 1'b1, 16'h0200, 16'h7777, 1'b0, 16'h0000, 4'd0);
      run4("alias", 1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd0);
      run4("alias", 2, 1'b0, 1'b1, 1'b0, 16'h1010, 16'h0000, 1'b0, 16'h0000, 4'd1);
      run4("alias", 3, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd2);
      run4("alias", 4, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd2);
      run4("alias", 5, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h7777, 4'd2);
      run4("alias", 6, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF, 4'd1);
      run4("alias", 7, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd0);
`endif

      // LATENCY=1: alternating write/read; each read returns the word just written.
      dprev = 16'h0000;
      for (int k = 0; k < 4; k++) begin
         dk = 16'hC000 + 16'(k) * 16'h0111;
         run1("lat1w", k, 1'b1, 1'b1, 16'h0050 + 16'(2*k), dk,
              (k == 0) ? 1'b0 : 1'b1, dprev, (k == 0) ? 4'd0 : 4'd1);
         run1("lat1r", k, 1'b1, 1'b0, 16'h0050 + 16'(2*k), 16'h0000,
              1'b0, 16'h0000, 4'd0);
         dprev = dk;
      end
      run1("lat1w", 4, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, dprev, 4'd1);
      run1("lat1r", 4, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
